// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC generation, credit-limited imem requests and an in-order fetch queue.
// Optional macro FETCH_TRACE_EN compiles in a simulation-only pop/redirect trace.
module fetch_stage #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_b_taken,
  input  logic [XLEN-1:0] i_b_pc,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            i_imem_req_ready,
  input  logic            i_imem_rsp_valid,
  input  logic [31:0]     i_imem_rsp_data,
  output logic            fq_valid,
  output logic [XLEN-1:0] fq_pc,
  output logic [31:0]     fq_instr,
  input  logic            i_dec_ready
);
  localparam int            PW      = $clog2(DEPTH);
  localparam int            CW      = PW + 1;
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] rsp_pc_reg, rsp_pc_next;
  logic [CW-1:0]   count_reg, count_next;
  logic [CW-1:0]   inflight_reg, inflight_next;
  logic [CW-1:0]   drop_reg, drop_next;
  logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
  logic            started_reg;

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];

  logic [CW:0]     credit_used;
  logic [XLEN-1:0] redirect_pc;
  logic            req_fire, rsp_fire, push, pop;

  assign redirect_pc = i_b_pc & ~XLEN'(3);
  assign credit_used = {1'b0, count_reg} + {1'b0, inflight_reg};

  // Queue entries plus outstanding requests never exceed DEPTH, so a push can never find the queue full.
  assign imem_req_valid = i_rst_n & started_reg & ~i_b_taken & (credit_used < DEPTH_W);
  assign imem_req_addr  = pc_reg;
  assign req_fire       = imem_req_valid & i_imem_req_ready;

  // Responses with nothing outstanding belong to requests abandoned by a reset.
  assign rsp_fire = i_imem_rsp_valid & (inflight_reg != '0);
  assign push     = rsp_fire & (drop_reg == '0) & ~i_b_taken;

  assign fq_valid = i_rst_n & (count_reg != '0) & ~i_b_taken;
  assign fq_pc    = pc_mem[rd_ptr_reg];
  assign fq_instr = instr_mem[rd_ptr_reg];
  assign pop      = fq_valid & i_dec_ready;

  always_comb begin
    pc_next       = pc_reg;
    rsp_pc_next   = rsp_pc_reg;
    count_next    = count_reg;
    drop_next     = drop_reg;
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    inflight_next = inflight_reg + CW'(req_fire) - CW'(rsp_fire);
    if (i_b_taken) begin
      pc_next     = redirect_pc;
      rsp_pc_next = redirect_pc;
      count_next  = '0;
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      // Every request still outstanding after this cycle is stale; older drops are a subset of them.
      drop_next   = inflight_next;
    end else begin
      if (req_fire)
        pc_next = pc_reg + XLEN'(4);
      if (rsp_fire && (drop_reg != '0))
        drop_next = drop_reg - CW'(1);
      if (push) begin
        wr_ptr_next = wr_ptr_reg + PW'(1);
        rsp_pc_next = rsp_pc_reg + XLEN'(4);
      end
      if (pop)
        rd_ptr_next = rd_ptr_reg + PW'(1);
      count_next = count_reg + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pc_reg       <= RESET_PC;
      rsp_pc_reg   <= RESET_PC;
      count_reg    <= '0;
      inflight_reg <= '0;
      drop_reg     <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      started_reg  <= 1'b0;
    end else begin
      pc_reg       <= pc_next;
      rsp_pc_reg   <= rsp_pc_next;
      count_reg    <= count_next;
      inflight_reg <= inflight_next;
      drop_reg     <= drop_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      started_reg  <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      pc_mem[wr_ptr_reg]    <= rsp_pc_reg;
      instr_mem[wr_ptr_reg] <= i_imem_rsp_data;
    end
  end

`ifdef FETCH_TRACE_EN
  logic [31:0] trace_cycle_reg;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      trace_cycle_reg <= '0;
    else
      trace_cycle_reg <= trace_cycle_reg + 32'd1;
    if (i_rst_n && pop)
      $display("fetch pop: pc=%h instr=%h cycle=%0d", fq_pc, fq_instr, trace_cycle_reg);
    if (i_rst_n && i_b_taken)
      $display("fetch redirect: target=%h cycle=%0d", redirect_pc, trace_cycle_reg);
  end
`else
  // Trace disabled: no display logic.
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus random traffic against an epoch-tagged model.
module tb_fetch_stage;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0, b_taken = 1'b0, req_ready = 1'b0, rsp_valid = 1'b0, dec_ready = 1'b0;
  logic [31:0] b_pc = '0, rsp_data = '0;
  logic        req_valid, fq_valid, w_req_valid, w_fq_valid;
  logic [31:0] req_addr, fq_pc, fq_instr, w_req_addr, w_fq_pc, w_fq_instr;

  fetch_stage #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_b_taken(b_taken), .i_b_pc(b_pc),
    .imem_req_valid(req_valid), .imem_req_addr(req_addr), .i_imem_req_ready(req_ready),
    .i_imem_rsp_valid(rsp_valid), .i_imem_rsp_data(rsp_data),
    .fq_valid(fq_valid), .fq_pc(fq_pc), .fq_instr(fq_instr), .i_dec_ready(dec_ready));

  fetch_stage #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .i_clk(clk), .i_rst_n(rst_n), .i_b_taken(b_taken), .i_b_pc(b_pc),
    .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr), .i_imem_req_ready(req_ready),
    .i_imem_rsp_valid(rsp_valid), .i_imem_rsp_data(rsp_data),
    .fq_valid(w_fq_valid), .fq_pc(w_fq_pc), .fq_instr(w_fq_instr), .i_dec_ready(dec_ready));

  int total = 0, bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [63:0] at(input logic [31:0] q[$], input int i);
    if (i < q.size()) return {32'h0, q[i]};
    return 'x;
  endfunction

  // Model: memory keeps outstanding requests tagged with the fetch epoch; a redirect or reset
  // starts a new epoch, and only responses from the current epoch reach the decode queue.
  logic [31:0] mq_addr[$];
  int          mq_epoch[$];
  logic [31:0] fq_m[$];
  logic [31:0] pc_m;
  int          epoch = 0, cyc = 0, hs_cnt = 0;
  bit          started = 0;

  logic [31:0] req_v_log[$], req_a_log[$], fqv_log[$], pop_pc_log[$], pop_cyc_log[$];
  logic [31:0] w_req_a_log[$], w_fq_pc_log[$], w_fq_instr_log[$];

  task automatic clear_logs();
    req_v_log.delete(); req_a_log.delete(); fqv_log.delete();
    pop_pc_log.delete(); pop_cyc_log.delete();
    w_req_a_log.delete(); w_fq_pc_log.delete(); w_fq_instr_log.delete();
    cyc = 0; hs_cnt = 0;
  endtask

  task automatic cycle(input bit bt, input logic [31:0] bpc, input bit dr, input bit rr, input bit re);
    bit rsp, exp_req, exp_fqv;
    rsp       = re && (mq_addr.size() > 0);
    b_taken   = bt;
    b_pc      = bpc;
    dec_ready = dr;
    req_ready = rr;
    rsp_valid = rsp;
    rsp_data  = rsp ? instr_of(mq_addr[0]) : $urandom;
    #1;
    exp_req = started && !bt && ((mq_addr.size() + fq_m.size()) < DEPTH);
    exp_fqv = !bt && (fq_m.size() > 0);
    check_eq("req_valid", req_valid, exp_req);
    if (exp_req) check_eq("req_addr", req_addr, pc_m);
    check_eq("fq_valid", fq_valid, exp_fqv);
    if (exp_fqv) begin
      check_eq("fq_pc", fq_pc, fq_m[0]);
      check_eq("fq_instr", fq_instr, instr_of(fq_m[0]));
    end
    req_v_log.push_back(32'(req_valid)); req_a_log.push_back(req_addr); fqv_log.push_back(32'(fq_valid));
    w_req_a_log.push_back(w_req_addr); w_fq_pc_log.push_back(w_fq_pc); w_fq_instr_log.push_back(w_fq_instr);
    if (exp_fqv && dr) begin
      pop_pc_log.push_back(fq_m[0]);
      pop_cyc_log.push_back(32'(cyc));
      void'(fq_m.pop_front());
    end
    if (rsp) begin
      if (!bt && mq_epoch[0] == epoch) fq_m.push_back(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_epoch.pop_front());
    end
    if (bt) begin
      fq_m.delete();
      pc_m = bpc & ~32'd3;
      epoch++;
    end else if (exp_req && rr) begin
      mq_addr.push_back(pc_m);
      mq_epoch.push_back(epoch);
      pc_m += 32'd4;
      hs_cnt++;
    end
    started = 1;
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Holds reset for n cycles; the memory keeps returning outstanding (now abandoned) responses.
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      rst_n     = 1'b0;
      b_taken   = 1'b0;
      dec_ready = 1'($urandom);
      req_ready = 1'($urandom);
      rsp_valid = mq_addr.size() > 0;
      rsp_data  = rsp_valid ? instr_of(mq_addr[0]) : 32'h0;
      if (rsp_valid) begin
        void'(mq_addr.pop_front());
        void'(mq_epoch.pop_front());
      end
      @(posedge clk);
      #1;
      check_eq("rst_req_valid", req_valid, 0);
      check_eq("rst_fq_valid", fq_valid, 0);
      check_eq("rst_w_req_valid", w_req_valid, 0);
      check_eq("rst_w_fq_valid", w_fq_valid, 0);
      @(negedge clk);
    end
    rst_n   = 1'b1;
    pc_m    = RESET_PC;
    fq_m.delete();
    epoch++;
    started = 0;
    clear_logs();
  endtask

  initial begin
    @(negedge clk);

    // Streaming with an always-ready 1-cycle memory, plus the wrapping reset PC instance.
    do_reset(2);
    for (int i = 0; i < 8; i++) cycle(0, 0, 1, 1, 1);
    check_eq("stream_first_v", at(req_v_log, 1), 1);
    check_eq("stream_first_addr", at(req_a_log, 1), 0);
    for (int i = 0; i < 4; i++) begin
      check_eq("stream_pop_pc", at(pop_pc_log, i), 4 * i);
      check_eq("stream_pop_cyc", at(pop_cyc_log, i), 3 + i);
    end
    check_eq("wrap_req0", at(w_req_a_log, 1), 32'hFFFF_FFFC);
    check_eq("wrap_req1", at(w_req_a_log, 2), 32'h0);
    check_eq("wrap_fq_pc", at(w_fq_pc_log, 3), 32'hFFFF_FFFC);
    check_eq("wrap_fq_instr", at(w_fq_instr_log, 3), instr_of(32'h0));

    // Decode stalled: credits stop requests at DEPTH, then the queue drains in order.
    do_reset(5);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 1, 1);
    check_eq("stall_req_count", hs_cnt, DEPTH);
    check_eq("stall_req_valid", at(req_v_log, 9), 0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 1, 1, 1);
    for (int i = 0; i < 4; i++) check_eq("drain_pc", at(pop_pc_log, i), 4 * i);

    // Redirect with two requests in flight to an unaligned target.
    do_reset(5);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 1, 0);
    cycle(1, 32'h103, 1, 1, 0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 1, 1, 1);
    check_eq("redir_req_v", at(req_v_log, 4), 1);
    check_eq("redir_req_addr", at(req_a_log, 4), 32'h100);
    check_eq("redir_first_pop", at(pop_pc_log, 0), 32'h100);

    // Redirect in the same cycle as a response and an attempted pop.
    do_reset(5);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 1);
    cycle(1, 32'h200, 1, 1, 1);
    for (int i = 0; i < 10; i++) cycle(0, 0, 1, 1, 1);
    check_eq("coinc_fq_valid", at(fqv_log, 4), 0);
    check_eq("coinc_first_pop", at(pop_pc_log, 0), 32'h200);

    // Reset with three requests outstanding; the late responses straddle the release.
    do_reset(5);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 1, 0);
    check_eq("pre_rst_inflight", mq_addr.size(), 3);
    do_reset(2);
    for (int i = 0; i < 7; i++) cycle(0, 0, 1, 1, 1);
    check_eq("rst_mid_fqv", at(fqv_log, 0), 0);
    check_eq("rst_mid_req_addr", at(req_a_log, 1), RESET_PC);
    check_eq("rst_mid_first_pop", at(pop_pc_log, 0), RESET_PC);

    // Random traffic.
    do_reset(5);
    for (int n = 0; n < 3000; n++) begin
      bit          bt, dr, rr, re;
      logic [31:0] bpc;
      if ($urandom_range(0, 499) == 0) do_reset(5);
      bt  = ($urandom_range(0, 15) == 0);
      bpc = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h3FF);
      dr  = ($urandom_range(0, 9) < 7);
      rr  = ($urandom_range(0, 9) < 7);
      re  = ($urandom_range(0, 9) < 6);
      cycle(bt, bpc, dr, rr, re);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter XLEN, default 32, address/PC width.
REQ-002 Parameter DEPTH, default 4, fetch queue entries; power of two, 2..16.
REQ-003 Parameter RESET_PC, default 0, PC loaded on reset.
REQ-004 i_clk  input  1  clock; all state on rising edge.
REQ-005 i_rst_n  input  1  reset, synchronous, active-low.
REQ-006 i_b_taken  input  1  redirect request from execute.
REQ-007 i_b_pc  input  XLEN  redirect target.
REQ-008 imem_req_valid  output  1  instruction memory request valid.
REQ-009 imem_req_addr  output  XLEN  request address, equals current PC.
REQ-010 i_imem_req_ready  input  1  memory accepts request.
REQ-011 i_imem_rsp_valid  input  1  response valid; responses return in request order.
REQ-012 i_imem_rsp_data  input  32  instruction word.
REQ-013 fq_valid  output  1  queue head valid toward decode.
REQ-014 fq_pc  output  XLEN  PC of head instruction.
REQ-015 fq_instr  output  32  head instruction.
REQ-016 i_dec_ready  input  1  decode consumes head.

Function
REQ-017 Request handshake = imem_req_valid & i_imem_req_ready; each advances pc_q by 4 (wraps modulo 2^XLEN) and increments inflight.
REQ-018 imem_req_valid SHALL be 1 only when count + inflight < DEPTH and i_b_taken = 0 (credit rule: queue can never overflow).
REQ-019 imem_req_addr and imem_req_valid SHALL be stable while valid & !ready, except on redirect.
REQ-020 Each i_imem_rsp_valid decrements inflight; if drop_cnt > 0 the response is discarded and drop_cnt decrements, else it is pushed with PC = rsp_pc_q, then rsp_pc_q += 4.
REQ-021 Pop = fq_valid & i_dec_ready; fq_valid = (count != 0) & !i_b_taken; head outputs combinational from queue head.
REQ-022 Simultaneous push and pop: count unchanged, both take effect; push into full queue is impossible by REQ-018.
REQ-023 Redirect cycle (i_b_taken = 1): pc_q and rsp_pc_q load {i_b_pc[XLEN-1:2], 2'b00}; queue flushed (count 0, pointers 0); no request issued; any response that cycle discarded.
REQ-024 On redirect, drop_cnt <= drop_cnt + inflight - (response in same cycle ? 1 : 0), clamped so that stale responses are exactly discarded; inflight unchanged by redirect.
REQ-025 Back-to-back redirects: the latest target wins; drop accounting accumulates.
REQ-026 Fetch latency: instruction at fq_* no earlier than one cycle after its response (registered queue write).

Reset
REQ-027 With i_rst_n = 0 at a clock edge: pc_q = rsp_pc_q = RESET_PC, count = inflight = drop_cnt = 0, queue pointers 0.
REQ-028 During and one cycle after reset: imem_req_valid = 0, fq_valid = 0; reset mid-transaction abandons in-flight requests, responses arriving before first post-reset request are ignored.

Configuration
REQ-029 Macro FETCH_TRACE_EN: when defined, a simulation-only display prints PC, instruction, and cycle on every pop, and target on every redirect; when undefined, no display code is compiled and ports/behaviour are identical.

Verification
REQ-030 Reset, ready always 1, 1-cycle memory: first request addr 0, fq_pc sequence 0,4,8,C with matching instr, one per cycle once primed.
REQ-031 i_dec_ready = 0 for 10 cycles, DEPTH=4: exactly 4 requests issued, then imem_req_valid = 0; releasing ready drains 0,4,8,C in order.
REQ-032 Two requests in flight, i_b_taken with i_b_pc = 0x103: next request addr 0x100; both stale responses dropped; first fq_pc = 0x100.
REQ-033 Redirect coinciding with response and pop: response dropped, fq_valid = 0 that cycle, drop_cnt counts only remaining stale responses.
REQ-034 XLEN=32, RESET_PC = 0xFFFFFFFC: second request addr 0x00000000 (wrap).
REQ-035 Assert i_rst_n = 0 with 3 in flight, release: request addr RESET_PC, queue empty, late responses never reach fq_*.
